rom_streamer: RTL and testbench

ROM_STREAMER -- requirements
Module: rom_streamer

---
 rtl/rom_streamer.sv | 121 ++++++++++++
 tb/tb_rom_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_streamer.sv
// rom_streamer: walks a synchronous ROM from address 0 and hands each word to a
// UART transmitter over a valid/ready handshake, one byte per FETCH/EVAL/SEND pass.
// Latency: first tx_valid two cycles after start is sampled. Stalls indefinitely while tx_ready=0.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - level request, only looked at in IDLE
//   rom_addr / rom_data   - registered address out, read data back one clock later
//   tx_data/tx_valid/tx_ready - byte handshake towards the transmitter
//   busy                  - state is not IDLE
//   done                  - single-cycle pulse at the end of a stream
//
// Build option: define ROM_STREAMER_TERM_EN to stop the stream at the first
// TERM_BYTE word (that word is never sent). Without it every word is sent.
module rom_streamer #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERM_BYTE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

`ifdef ROM_STREAMER_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   txd_nxt;
  logic                    txv_nxt;
  logic                    term_hit;

  // Folds to constant 0 when the terminator feature is compiled out.
  assign term_hit = TERM_EN && (rom_data == TERM_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rom_addr <= addr_nxt;
      tx_data  <= txd_nxt;
      tx_valid <= txv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    txd_nxt   = tx_data;
    txv_nxt   = tx_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
        end
      end
      // rom_addr is presented here; the ROM answers during EVAL.
      FETCH: state_nxt = EVAL;
      EVAL: begin
        if (term_hit) begin
          state_nxt = DONE;
        end else begin
          txd_nxt   = rom_data;
          txv_nxt   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          txv_nxt = 1'b0;
          // Stop at the last word rather than letting the address wrap.
          if (rom_addr == LAST_ADDR) begin
            state_nxt = DONE;
          end else begin
            addr_nxt  = rom_addr + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      DONE: begin
        addr_nxt  = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        txv_nxt   = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rom_streamer.sv
`timescale 1ns/1ps
module tb_rom_streamer;
  localparam int         AW    = 5;
  localparam int         DW    = 8;
  localparam int         DEPTH = 32;
  localparam logic [7:0] TERM  = 8'h00;
`ifdef ROM_STREAMER_TERM_EN
  localparam bit TERM_EN_TB = 1'b1;
`else
  localparam bit TERM_EN_TB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid, busy, done;

  logic [7:0] rom [DEPTH];
  logic [7:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data for the sampled address appears one clock later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TERM_BYTE(TERM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference: the bytes a stream must deliver, straight from the ROM contents.
  function automatic void build_exp();
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      if (TERM_EN_TB && rom[a] == TERM) break;
      exp_q.push_back(rom[a]);
    end
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0: rom[i] = i[7:0];
        1: rom[i] = (i == 0) ? 8'h48 : (i == 1) ? 8'h49 : (i == 2) ? 8'h00 : 8'h20 + i[7:0];
        2: rom[i] = 8'hA0 + i[7:0];
        default: rom[i] = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      endcase
    end
  endtask

  // Called on a negedge with the DUT idle. Runs one stream to completion.
  task automatic run_stream(input int ready_pct, input int stall_addr, input int poke_at,
                            output int n_got, output logic [7:0] first_got);
    logic [7:0]    got [$];
    int            dones = 0;
    int            first_evt = -1;
    int            idx = 0;
    int            stall_left = 5;
    bit            prev_stall = 1'b0;
    bit            ended = 1'b0;
    logic [7:0]    prev_d = 8'h00;
    logic [AW-1:0] prev_a = '0;
    build_exp();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("addr_after_start", rom_addr, 0);
    while (idx < 3000) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (first_evt < 0 && (tx_valid || done)) first_evt = idx;
      if (done) dones++;
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, prev_d);
        check("stall_addr", rom_addr, prev_a);
      end
      start = (idx == poke_at);
      if (tx_valid && stall_addr >= 0 && rom_addr == stall_addr[AW-1:0] && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = ($urandom_range(99) < ready_pct);
      end
      if (tx_valid && tx_ready) begin
        check("send_addr", rom_addr, got.size());
        got.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
      prev_a = rom_addr;
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
    tx_ready = 1'b0;
    check("stream_ended", ended, 1);
    check("done_pulses", dones, 1);
    // tx_valid (or done, when ROM[0] terminates) is seen in the third state after sampling.
    check("first_event_cycle", first_evt, 2);
    check("addr_after_stream", rom_addr, 0);
    check("byte_count", got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check("byte_value", got[k], exp_q[k]);
    n_got = got.size();
    first_got = (got.size() > 0) ? got[0] : 8'h00;
  endtask

  typedef struct {
    int         fill_kind;
    int         ready_pct;
    int         stall_addr;
    int         poke_at;
    int         exp_len;
    logic [7:0] exp_first;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int         n_got;
    logic [7:0] first_got;
    bit         seen;

`ifdef ROM_STREAMER_TERM_EN
    vecs[0] = '{0, 100, -1, -1, 0,  8'h00};
    vecs[1] = '{1, 100, -1, -1, 2,  8'h48};
    vecs[2] = '{1, 100,  1, -1, 2,  8'h48};
    vecs[3] = '{2,  50, -1, -1, 32, 8'hA0};
    vecs[4] = '{2, 100, -1,  4, 32, 8'hA0};
`else
    vecs[0] = '{0, 100, -1, -1, 32, 8'h00};
    vecs[1] = '{1, 100, -1, -1, 32, 8'h48};
    vecs[2] = '{1, 100,  1, -1, 32, 8'h48};
    vecs[3] = '{2,  50, -1, -1, 32, 8'hA0};
    vecs[4] = '{2, 100, -1,  4, 32, 8'hA0};
`endif

    fill(0);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_data", tx_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", busy, 0);

    foreach (vecs[v]) begin
      fill(vecs[v].fill_kind);
      run_stream(vecs[v].ready_pct, vecs[v].stall_addr, vecs[v].poke_at, n_got, first_got);
      check("vec_len", n_got, vecs[v].exp_len);
      if (vecs[v].exp_len > 0) check("vec_first", first_got, vecs[v].exp_first);
      @(negedge clk);
    end

    for (int r = 0; r < 6; r++) begin
      fill(3);
      run_stream($urandom_range(100, 30), -1, -1, n_got, first_got);
      @(negedge clk);
    end

    // start held high: streams run back to back with a single IDLE cycle between.
    fill(2);
    tx_ready = 1'b1;
    start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_first_done", seen, 1);
    @(negedge clk);
    check("b2b_gap_idle", busy, 0);
    @(negedge clk);
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_addr", rom_addr, 0);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_second_end", seen, 1);
    tx_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of byte 2's SEND.
    fill(2);
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (tx_valid && rom_addr == 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_reach_byte2", seen, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    rst_n = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("post_rst_no_done", done, 0);
    run_stream(100, -1, -1, n_got, first_got);
    check("post_rst_first", first_got, 8'hA0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
